// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Merges load-use, divide occupancy, bus wait states and exception flushes.
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6,
  parameter int MEM_TIMEOUT = 255,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lwstallD,
  input  logic              div_opE,
  input  logic              mem_reqM,
  input  logic              mem_readyM,
  input  logic              flush_req,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              div_start,
  output logic              div_valid,
  output logic              div_cancel,
  output logic              mem_err,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int MW = $clog2(MEM_TIMEOUT + 1);
  // The start cycle is the first of DIV_CYCLES occupancy cycles, so RUN lasts DIV_CYCLES-1.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam logic [MW-1:0]    MEM_MAX  = MW'(MEM_TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [MW-1:0]    mem_cnt;
  logic             flush_pend;
  logic             mem_stall, flush_now, div_stall, lw_haz;

  // Every request is masked while rst is high so no pulse can escape during reset.
  assign mem_stall = ~rst & mem_reqM & ~mem_readyM;
  assign flush_now = ~rst & (flush_req | flush_pend) & ~mem_stall;
  assign lw_haz    = ~rst & lwstallD;

  always_comb begin
    div_stall = 1'b0;
    case (state)
      S_IDLE:  div_stall = ~rst & div_opE;
      S_RUN:   div_stall = 1'b1;
      default: div_stall = 1'b0;
    endcase
  end

  assign div_start  = (state == S_IDLE) & ~rst & div_opE & ~mem_stall & ~flush_now;
  assign div_valid  = (state == S_RUN) & (cnt == '0) & ~flush_now;
  assign div_cancel = (state == S_RUN) & flush_now;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (div_start) state_nx = S_RUN;
      S_RUN: begin
        if (flush_now)        state_nx = S_IDLE;
        else if (cnt == '0)   state_nx = S_DONE;
      end
      S_DONE: if (flush_now || !mem_stall) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (div_start)
        cnt <= DIV_LOAD;
      else if (state == S_RUN && cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flush_pend <= 1'b0;
    else if (flush_now)
      flush_pend <= 1'b0;
    else if (flush_req && mem_stall)
      flush_pend <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cnt <= '0;
      mem_err <= 1'b0;
    end else if (mem_stall) begin
      if (mem_cnt != MEM_MAX)
        mem_cnt <= mem_cnt + MW'(1);
      if (mem_cnt == MEM_MAX - MW'(1))
        mem_err <= 1'b1;
    end else begin
      mem_cnt <= '0;
    end
  end

  assign stallM = mem_stall;
  assign stallE = ~flush_now & (mem_stall | div_stall);
  assign stallF = ~flush_now & (mem_stall | div_stall | lw_haz);
  assign stallD = stallF;
  assign flushD = flush_now;
  assign flushE = flush_now | (lw_haz & ~div_stall & ~mem_stall);
  assign flushM = flush_now | (div_stall & ~mem_stall);
  assign flushW = mem_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (stallF)
      stall_cycles <= stall_cycles + PERF_W'(1);
  end

endmodule
